shift_unit: RTL

Sequential, parametrised successor to the combinational shifter in the core datapath. It accepts one operand, a shift count and a shift mode over a valid/ready handshake. It shifts iteratively by one bit per cycle in LSL, LSR, ASR or ROR mode, then returns the result with carry and zero flags over a second valid/ready handshake. It sits beside the ALU as a multi-cycle execution unit, trading area for latency.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 27 ++
 rtl/shift_unit.sv | 71 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types for the iterative shift unit: operation modes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// One 1-bit shift/rotate step; bit_out is the bit that leaves y this step.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] y,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] y_next,
  output logic             bit_out
);

  always_comb begin
    y_next  = y;
    bit_out = y[0];
    unique case (mode)
      SH_LSL: begin
        y_next  = {y[WIDTH-2:0], 1'b0};
        bit_out = y[WIDTH-1];
      end
      SH_LSR: y_next = {1'b0, y[WIDTH-1:1]};
      SH_ASR: y_next = {y[WIDTH-1], y[WIDTH-1:1]};
      SH_ROR: y_next = {y[0], y[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shifter: accept, shift one bit per cycle, hold the result until taken.
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [CNT_W-1:0] shift_count,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             busy
);

  shift_state_t     state;
  shift_mode_t      mode_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] y_next;
  logic             bit_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .y       (y),
    .mode    (mode_q),
    .y_next  (y_next),
    .bit_out (bit_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mode_q <= SH_LSL;
      cnt    <= '0;
      y      <= '0;
      carry  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          mode_q <= shift_mode_t'(mode);
          y      <= a;
          cnt    <= shift_count;
          carry  <= 1'b0;
          state  <= (shift_count == '0) ? DONE : SHIFT;
        end
        // cnt is always >= 1 here, so the decrement cannot wrap
        SHIFT: begin
          y     <= y_next;
          carry <= bit_out;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs come from the state register only, never from inputs.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign zero      = (y == '0);

endmodule
